// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dfilt_pkg.sv
// Shared definitions for the synchronising glitch filter.
//   - FSM state codes (2 bits)
//   - qualification counter width
//   - legal ranges for SYNC_STAGES / FILT_CYCLES plus a range-check helper
package gf180mcu_fd_sc_mcu7t5v0__dfilt_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] ST_LO   = 2'd0;
  localparam logic [1:0] QUAL_HI = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] QUAL_LO = 2'd3;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = 255;

  function automatic bit params_ok(input int sync_stages, input int filt_cycles);
    return (sync_stages >= SYNC_MIN) && (sync_stages <= SYNC_MAX) &&
           (filt_cycles >= FILT_MIN) && (filt_cycles <= FILT_MAX);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dfilt_sync_func.sv
// Behavioural core of the glitch filter: synchroniser chain, qualification
// FSM with run-length counter, registered level and edge pulses.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   i      raw asynchronous input
//   en     1 = qualify new levels for FILT_CYCLES samples, 0 = bypass
//   z      filtered level
//   zr/zf  one-cycle pulses on z rising / falling
//   VDD/VSS supply pass-through (USE_POWER_PINS only)
//
// state   | meaning
// --------+------------------------------------------------------
// ST_LO   | stable low, z=0
// QUAL_HI | s=1 seen, counting consecutive high samples, z=0
// ST_HI   | stable high, z=1
// QUAL_LO | s=0 seen, counting consecutive low samples, z=1
module gf180mcu_fd_sc_mcu7t5v0__dfilt_sync_func
  import gf180mcu_fd_sc_mcu7t5v0__dfilt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic clk,
  input  logic rst_n,
  input  logic i,
  input  logic en,
  output logic z,
  output logic zr,
  output logic zf
);

  if (!params_ok(SYNC_STAGES, FILT_CYCLES)) begin : g_param_err
    $error("dfilt_sync: SYNC_STAGES must be 2..4 and FILT_CYCLES 1..255");
  end

  // Terminal count: the sample that makes the run FILT_CYCLES long arrives
  // while cnt holds FILT_CYCLES-1, so cnt never goes past that value.
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   z_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z;
    if (!en) begin
      // Bypass also abandons any pending qualification, so re-enabling
      // resumes from the stable state that matches z.
      state_d = s ? ST_HI : ST_LO;
      cnt_d   = '0;
      z_d     = s;
    end else begin
      case (state_q)
        ST_LO: begin
          if (s) begin
            if (FILT_CYCLES == 1) begin
              state_d = ST_HI;
              z_d     = 1'b1;
            end else begin
              state_d = QUAL_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        QUAL_HI: begin
          if (s) begin
            if (cnt_q == FILT_LAST) begin
              state_d = ST_HI;
              cnt_d   = '0;
              z_d     = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_LO;
            cnt_d   = '0;
          end
        end
        ST_HI: begin
          if (!s) begin
            if (FILT_CYCLES == 1) begin
              state_d = ST_LO;
              z_d     = 1'b0;
            end else begin
              state_d = QUAL_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        QUAL_LO: begin
          if (!s) begin
            if (cnt_q == FILT_LAST) begin
              state_d = ST_LO;
              cnt_d   = '0;
              z_d     = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_HI;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_LO;
          cnt_d   = '0;
          z_d     = 1'b0;
        end
      endcase
    end
  end

  // Pulses are registered alongside z so all three outputs share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      z       <= 1'b0;
      zr      <= 1'b0;
      zf      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z       <= z_d;
      zr      <= z_d & ~z;
      zf      <= ~z_d & z;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dfilt_sync.sv
// Synchronising glitch filter cell wrapper. Z drives the downstream buf_4,
// so every output here is a flop output aligned to CLK.
//
// Ports:
//   CLK      rising-edge clock
//   RN       asynchronous active-low reset
//   I        raw asynchronous input (no timing relation to CLK)
//   EN       1 = qualify, 0 = bypass qualification
//   Z        filtered synchronised level
//   ZR / ZF  one-cycle pulses on Z rising / falling
//   VDD/VSS  supplies (USE_POWER_PINS only)
module gf180mcu_fd_sc_mcu7t5v0__dfilt_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RN,
  input  logic I,
  input  logic EN,
  output logic Z,
  output logic ZR,
  output logic ZF
);

  gf180mcu_fd_sc_mcu7t5v0__dfilt_sync_func #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_func (
`ifdef USE_POWER_PINS
    .VDD  (VDD),
    .VSS  (VSS),
`endif
    .clk  (CLK),
    .rst_n(RN),
    .i    (I),
    .en   (EN),
    .z    (Z),
    .zr   (ZR),
    .zf   (ZF)
  );

`ifndef FUNCTIONAL
  // I is deliberately left without a timing check: it is asynchronous.
  specify
    (posedge CLK => Z)  = (1.0, 1.0);
    (posedge CLK => ZR) = (1.0, 1.0);
    (posedge CLK => ZF) = (1.0, 1.0);
    (negedge RN => Z)   = (1.0, 1.0);
    (negedge RN => ZR)  = (1.0, 1.0);
    (negedge RN => ZF)  = (1.0, 1.0);
    $setuphold(posedge CLK, EN, 0, 0);
    $recrem(posedge RN, posedge CLK, 0, 0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dfilt_sync.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__dfilt_sync;

  localparam int N = 3;

  logic       CLK = 1'b0;
  logic       RN  = 1'b1;
  logic       I   = 1'b0;
  logic       EN  = 1'b1;
  logic [2:0] z_w, zr_w, zf_w;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Instance 0: defaults. Instance 1: deep sync, no filtering. Instance 2: max filter.
  gf180mcu_fd_sc_mcu7t5v0__dfilt_sync #(.SYNC_STAGES(2), .FILT_CYCLES(4)) dut0 (
    .CLK(CLK), .RN(RN), .I(I), .EN(EN), .Z(z_w[0]), .ZR(zr_w[0]), .ZF(zf_w[0]));
  gf180mcu_fd_sc_mcu7t5v0__dfilt_sync #(.SYNC_STAGES(4), .FILT_CYCLES(1)) dut1 (
    .CLK(CLK), .RN(RN), .I(I), .EN(EN), .Z(z_w[1]), .ZR(zr_w[1]), .ZF(zf_w[1]));
  gf180mcu_fd_sc_mcu7t5v0__dfilt_sync #(.SYNC_STAGES(2), .FILT_CYCLES(255)) dut2 (
    .CLK(CLK), .RN(RN), .I(I), .EN(EN), .Z(z_w[2]), .ZR(zr_w[2]), .ZF(zf_w[2]));

  function automatic int ss_of(input int n);
    return (n == 1) ? 4 : 2;
  endfunction

  function automatic int fc_of(input int n);
    return (n == 0) ? 4 : ((n == 1) ? 1 : 255);
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the filtered level follows the synchronised sample once that
  // sample has disagreed with it for fc consecutive edges (immediately when
  // bypassed). The sync chain is a plain delay line of sampled I values.
  logic [3:0] m_chain [N];
  logic       m_z  [N];
  logic       m_zr [N];
  logic       m_zf [N];
  int         m_run[N];

  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int n = 0; n < N; n++) begin
        m_chain[n] = '0;
        m_z[n] = 1'b0; m_zr[n] = 1'b0; m_zf[n] = 1'b0; m_run[n] = 0;
      end
    end else begin
      for (int n = 0; n < N; n++) begin
        logic s_seen, z_new;
        s_seen = m_chain[n][ss_of(n)-1];
        m_chain[n] = {m_chain[n][2:0], I};
        z_new = m_z[n];
        if (!EN) begin
          z_new = s_seen;
          m_run[n] = 0;
        end else if (s_seen != m_z[n]) begin
          m_run[n] = m_run[n] + 1;
          if (m_run[n] == fc_of(n)) begin
            z_new = s_seen;
            m_run[n] = 0;
          end
        end else begin
          m_run[n] = 0;
        end
        m_zr[n] = z_new & ~m_z[n];
        m_zf[n] = ~z_new & m_z[n];
        m_z[n]  = z_new;
      end
    end
  end

  always @(negedge CLK) begin
    for (int n = 0; n < N; n++) begin
      chk($sformatf("model_z%0d", n),  z_w[n],  m_z[n]);
      chk($sformatf("model_zr%0d", n), zr_w[n], m_zr[n]);
      chk($sformatf("model_zf%0d", n), zf_w[n], m_zf[n]);
      chk($sformatf("zr_zf_excl%0d", n), zr_w[n] & zf_w[n], 1'b0);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int zr_cnt;
    I  = 1'b1;
    EN = 1'b1;
    #1 RN = 1'b0;

    // Reset held with I=1 and CLK running.
    for (int k = 0; k < 4; k++) begin
      edges(1);
      chk("rst_hold_all0", |(z_w | zr_w | zf_w), 1'b0);
    end
    RN = 1'b1;
    edges(5); chk("rst_rel_z_e5", z_w[0], 1'b0);
    edges(1); chk("rst_rel_z_e6", z_w[0], 1'b1); chk("rst_rel_zr_e6", zr_w[0], 1'b1);
    edges(1); chk("rst_rel_zr_e7", zr_w[0], 1'b0); chk("rst_rel_z_e7", z_w[0], 1'b1);

    // Short low glitch while high.
    I = 1'b0; edges(2); I = 1'b1;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      chk("low_glitch_z", z_w[0], 1'b1);
      chk("low_glitch_zf", zf_w[0], 1'b0);
    end

    // Accepted fall.
    I = 1'b0;
    edges(5); chk("fall_z_e5", z_w[0], 1'b1);
    edges(1); chk("fall_z_e6", z_w[0], 1'b0); chk("fall_zf_e6", zf_w[0], 1'b1);
    edges(1); chk("fall_zf_e7", zf_w[0], 1'b0);
    edges(4);

    // Three-period high glitch is rejected.
    I = 1'b1; edges(3); I = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      chk("hi_glitch3_z", z_w[0], 1'b0);
      chk("hi_glitch3_zr", zr_w[0], 1'b0);
    end

    // Four-period high pulse is accepted, then falls back.
    I = 1'b1; edges(4); I = 1'b0;
    edges(1); chk("hi_pulse4_z_e5", z_w[0], 1'b0);
    edges(1); chk("hi_pulse4_z_e6", z_w[0], 1'b1); chk("hi_pulse4_zr_e6", zr_w[0], 1'b1);
    edges(10); chk("hi_pulse4_settle", z_w[0], 1'b0);

    // Bypass.
    EN = 1'b0; edges(3);
    I = 1'b1;
    edges(2); chk("byp_rise_z_e2", z_w[0], 1'b0);
    edges(1); chk("byp_rise_z_e3", z_w[0], 1'b1); chk("byp_rise_zr_e3", zr_w[0], 1'b1);
    I = 1'b0;
    edges(2); chk("byp_fall_z_e2", z_w[0], 1'b1);
    edges(1); chk("byp_fall_z_e3", z_w[0], 1'b0); chk("byp_fall_zf_e3", zf_w[0], 1'b1);

    // EN drops while qualifying high with cnt=2.
    EN = 1'b1; edges(4);
    I = 1'b1; edges(4);
    chk("endrop_z_e4", z_w[0], 1'b0);
    EN = 1'b0;
    edges(1); chk("endrop_z_e5", z_w[0], 1'b1); chk("endrop_zr_e5", zr_w[0], 1'b1);
    zr_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      if (zr_w[0]) zr_cnt++;
    end
    chk("endrop_zr_once", zr_cnt == 0, 1'b1);

    // Re-enable resumes from the high stable state.
    EN = 1'b1; I = 1'b0;
    edges(5); chk("reen_z_e5", z_w[0], 1'b1);
    edges(1); chk("reen_z_e6", z_w[0], 1'b0); chk("reen_zf_e6", zf_w[0], 1'b1);
    edges(2);

    // Reset mid-qualification: full latency applies after release.
    I = 1'b1; edges(4);
    RN = 1'b0;
    #1 chk("midq_rst_z", z_w[0], 1'b0); chk("midq_rst_zr", zr_w[0], 1'b0);
    edges(2);
    RN = 1'b1;
    edges(5); chk("midq_rel_z_e5", z_w[0], 1'b0);
    edges(1); chk("midq_rel_z_e6", z_w[0], 1'b1); chk("midq_rel_zr_e6", zr_w[0], 1'b1);

    // Asynchronous reset from Z=1 without a clock edge.
    #2 RN = 1'b0;
    #1 chk("async_rst_z0", z_w[0], 1'b0);
    chk("async_rst_z1", z_w[1], 1'b0);
    chk("async_rst_z2", z_w[2], 1'b0);
    I = 1'b0;
    edges(1);
    RN = 1'b1;

    // Parameter corners: SYNC=4/FILT=1 at edge 5, FILT=255 at edge 257.
    edges(300);
    I = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      edges(1);
      chk("corner_s4f1_z", z_w[1], (k >= 5) ? 1'b1 : 1'b0);
      chk("corner_f255_z", z_w[2], (k >= 257) ? 1'b1 : 1'b0);
      chk("corner_f255_zr", zr_w[2], (k == 257) ? 1'b1 : 1'b0);
    end

    edges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
